// File: rtl/if_prefetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// The memory may ack in the same cycle it first sees imem_req.
interface if_prefetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: one-outstanding req/ack fetcher feeding a DEPTH-entry
// queue of {PC+4, instruction} pairs, flushed and redirected by Branch_taken.
module if_prefetch_stage #(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int             CNT_W    = $clog2(DEPTH) + 1,
  localparam int             PTR_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_freeze,
  input  logic                i_sram_freeze,
  input  logic                i_branch_taken,
  input  logic [ADDR_W-1:0]   i_branch_addr,
  if_prefetch_stage_if.master imem,
  output logic                o_valid,
  output logic [ADDR_W-1:0]   o_pc,
  output logic [INST_W-1:0]   o_instruction,
  output logic [CNT_W-1:0]    o_occupancy
);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_next;
  logic [ADDR_W-1:0] r_req_addr, w_req_addr_next;
  logic              r_imem_req;

  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]  r_count, w_count_next;

  logic              w_pop, w_push, w_space;
  logic [ADDR_W-1:0] w_req_addr_inc;

  assign w_pop          = (r_count != '0) && !i_freeze && !i_sram_freeze;
  assign w_push         = (r_state == REQ) && imem.imem_ack && !i_branch_taken;
  assign w_count_next   = r_count - CNT_W'(w_pop) + CNT_W'(w_push);
  assign w_space        = w_count_next < CNT_W'(DEPTH);
  assign w_req_addr_inc = r_req_addr + ADDR_W'(4);

  // A request is never retracted: a branch without an ack parks in DROP until the stale response arrives.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_req_addr_next = r_req_addr;
    unique case (r_state)
      IDLE: begin
        if (i_branch_taken) begin
          w_fetch_pc_next = i_branch_addr;
          w_req_addr_next = i_branch_addr;
          w_state_next    = REQ;
        end else if (w_space) begin
          w_req_addr_next = r_fetch_pc;
          w_state_next    = REQ;
        end
      end
      REQ: begin
        if (i_branch_taken) begin
          w_fetch_pc_next = i_branch_addr;
          if (imem.imem_ack) begin
            w_req_addr_next = i_branch_addr;
          end else begin
            w_state_next    = DROP;
          end
        end else if (imem.imem_ack) begin
          w_fetch_pc_next = w_req_addr_inc;
          if (w_space) begin
            w_req_addr_next = w_req_addr_inc;
          end else begin
            w_state_next    = IDLE;
          end
        end
      end
      DROP: begin
        if (i_branch_taken) begin
          w_fetch_pc_next = i_branch_addr;
        end
        if (imem.imem_ack) begin
          w_req_addr_next = i_branch_taken ? i_branch_addr : r_fetch_pc;
          w_state_next    = REQ;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= '0;
      r_imem_req <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_req_addr <= w_req_addr_next;
      r_imem_req <= (w_state_next != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_branch_taken) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= w_req_addr_inc;
      r_inst_mem[r_wr_ptr] <= imem.imem_rdata;
    end
  end

  assign imem.imem_req  = r_imem_req;
  assign imem.imem_addr = r_req_addr;
  assign o_valid        = (r_count != '0);
  assign o_pc           = o_valid ? r_pc_mem[r_rd_ptr] : '0;
  assign o_instruction  = o_valid ? r_inst_mem[r_rd_ptr] : '0;
  assign o_occupancy    = r_count;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_if_prefetch_stage;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, rst2_n;
  logic              freeze, sramFreeze, branchTaken;
  logic [ADDR_W-1:0] branchAddr;
  logic              zeroWait, tbAck;
  logic [INST_W-1:0] tbRdata;

  logic              valid, valid2;
  logic [ADDR_W-1:0] pc, pc2;
  logic [INST_W-1:0] instr, instr2;
  logic [CNT_W-1:0]  occ, occ2;

  int errors = 0;
  int checks = 0;

  if_prefetch_stage_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();
  if_prefetch_stage_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus2 ();

  assign bus.imem_ack    = zeroWait ? bus.imem_req : tbAck;
  assign bus.imem_rdata  = zeroWait ? bus.imem_addr : tbRdata;
  assign bus2.imem_ack   = bus2.imem_req;
  assign bus2.imem_rdata = bus2.imem_addr;

  if_prefetch_stage #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_freeze(freeze), .i_sram_freeze(sramFreeze),
    .i_branch_taken(branchTaken), .i_branch_addr(branchAddr),
    .imem(bus),
    .o_valid(valid), .o_pc(pc), .o_instruction(instr), .o_occupancy(occ)
  );

  // Second instance exercises address wrap from a reset PC near the top of the space.
  if_prefetch_stage #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .i_freeze(1'b0), .i_sram_freeze(1'b0),
    .i_branch_taken(1'b0), .i_branch_addr(32'h0),
    .imem(bus2),
    .o_valid(valid2), .o_pc(pc2), .o_instruction(instr2), .o_occupancy(occ2)
  );

  typedef struct {
    logic        fz, sfz, br;
    logic [31:0] baddr;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] ePc, eInst;
    int          eOcc;
  } vec_t;
  vec_t vecs[14];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t        mQ[$];
  bit          mBusy, mStale;
  logic [31:0] mBusAddr, mNextPc;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic fz, input logic sfz, input logic br, input logic [31:0] baddr);
    freeze      = fz;
    sramFreeze  = sfz;
    branchTaken = br;
    branchAddr  = baddr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic eReq, input logic [31:0] eAddr, input logic eValid,
                          input logic [31:0] ePc, input logic [31:0] eInst, input int eOcc);
    checkOutput({tag, ".imem_req"},    32'(bus.imem_req), 32'(eReq));
    checkOutput({tag, ".imem_addr"},   bus.imem_addr, eAddr);
    checkOutput({tag, ".valid"},       32'(valid), 32'(eValid));
    checkOutput({tag, ".PC"},          pc, ePc);
    checkOutput({tag, ".Instruction"}, instr, eInst);
    checkOutput({tag, ".occupancy"},   32'(occ), 32'(eOcc));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic modelReset();
    mQ.delete();
    mBusy    = 1'b0;
    mStale   = 1'b0;
    mBusAddr = 32'h0;
    mNextPc  = 32'h0;
  endtask

  // One clock of the fetch stage described by its rules, not by its state encoding.
  task automatic modelStep(input logic fz, input logic sfz, input logic br, input logic [31:0] baddr,
                           input logic ack, input logic [31:0] rdata);
    bit pop;
    bit resp;
    pop  = (mQ.size() != 0) && !fz && !sfz;
    resp = mBusy && ack;
    if (br) mQ.delete();
    else if (pop) void'(mQ.pop_front());
    if (br) begin
      mNextPc = baddr;
      if (!mBusy || resp) begin
        mBusy    = 1'b1;
        mStale   = 1'b0;
        mBusAddr = baddr;
      end else begin
        mStale = 1'b1;
      end
    end else if (resp) begin
      if (mStale) begin
        mStale   = 1'b0;
        mBusAddr = mNextPc;
      end else begin
        mQ.push_back('{mBusAddr + 32'd4, rdata});
        mNextPc = mBusAddr + 32'd4;
        if (mQ.size() < DEPTH) mBusAddr = mNextPc;
        else mBusy = 1'b0;
      end
    end else if (!mBusy && mQ.size() < DEPTH) begin
      mBusy    = 1'b1;
      mBusAddr = mNextPc;
    end
  endtask

  initial begin
    int memWait;
    logic        rFz, rSfz, rBr;
    logic [31:0] rBaddr;
    logic        eValid;

    rst_n  = 1'b0;
    rst2_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    zeroWait = 1'b1;
    tbAck    = 1'b0;
    tbRdata  = 32'h0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   32'h0,   0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h4,   32'h0,   1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   32'h0,   2};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h4,   32'h0,   3};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h4,   32'h0,   4};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h4,   32'h0,   4};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h8,   32'h4,   3};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'hC,   32'h8,   3};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'h10,  32'hC,   3};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h18,  1'b1, 32'h10,  32'hC,   4};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h1C,  1'b1, 32'h14,  32'h10,  3};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0,   0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h104, 32'h100, 1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h108, 32'h104, 1};

    @(negedge clk);
    @(negedge clk);
    checkAll("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].fz, vecs[i].sfz, vecs[i].br, vecs[i].baddr);
      tick();
      checkAll($sformatf("vec%0d", i), vecs[i].eReq, vecs[i].eAddr, vecs[i].eValid,
               vecs[i].ePc, vecs[i].eInst, vecs[i].eOcc);
    end

    // Branch while a slow request to 0x20 is outstanding.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    zeroWait = 1'b0;
    tbAck    = 1'b0;
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h20);
    tick();
    checkAll("brIssue", 1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
    tick();
    checkAll("brDrop1", 1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkAll("brDrop2", 1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 0);
    tbAck   = 1'b1;
    tbRdata = 32'hBAD0_BAD0;
    tick();
    checkAll("brStaleAck", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 0);
    tbRdata = 32'h1234_5678;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkAll("brTarget", 1'b1, 32'h104, 1'b1, 32'h104, 32'h1234_5678, 1);
    tbAck = 1'b0;

    // Reset mid-request, then a late ack while idle.
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("rstAsync", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 0);
    tbAck = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tbAck = 1'b0;
    checkAll("rstLateAck", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 0);

    // Address wrap on the second instance.
    @(negedge clk);
    rst2_n = 1'b1;
    tick();
    checkOutput("wrap0.imem_addr", bus2.imem_addr, 32'hFFFF_FFF8);
    checkOutput("wrap0.valid", 32'(valid2), 32'h0);
    tick();
    checkOutput("wrap1.imem_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    checkOutput("wrap1.PC", pc2, 32'hFFFF_FFFC);
    checkOutput("wrap1.Instruction", instr2, 32'hFFFF_FFF8);
    tick();
    checkOutput("wrap2.imem_addr", bus2.imem_addr, 32'h0);
    checkOutput("wrap2.valid", 32'(valid2), 32'h1);
    checkOutput("wrap2.PC", pc2, 32'h0);
    checkOutput("wrap2.Instruction", instr2, 32'hFFFF_FFFC);
    checkOutput("wrap2.occupancy", 32'(occ2), 32'h1);
    rst2_n = 1'b0;

    // Randomized traffic against the reference model.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tbAck = 1'b0;
    doReset();
    modelReset();
    memWait = 0;
    for (int c = 0; c < 3000; c++) begin
      rFz  = ($urandom_range(0, 3) == 0);
      rSfz = ($urandom_range(0, 7) == 0);
      rBr  = ($urandom_range(0, 15) == 0);
      rBaddr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                           : $urandom;
      if (mBusy) begin
        if (memWait == 0) begin
          tbAck   = 1'b1;
          memWait = $urandom_range(0, 3);
        end else begin
          tbAck   = 1'b0;
          memWait = memWait - 1;
        end
      end else begin
        tbAck = ($urandom_range(0, 7) == 0);
      end
      tbRdata = $urandom;
      applyStimulus(rFz, rSfz, rBr, rBaddr);
      modelStep(rFz, rSfz, rBr, rBaddr, tbAck, tbRdata);
      tick();
      eValid = (mQ.size() != 0);
      checkAll($sformatf("rnd%0d", c), mBusy, mBusAddr, eValid,
               eValid ? mQ[0].pc : 32'h0, eValid ? mQ[0].inst : 32'h0, mQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
